bus_master: RTL and testbench

- Single-outstanding bus initiator. Turns a valid/ready command stream into read/write cycles on the shared register bus, and returns read data or write completion on a valid/ready response stream.
- Drives the bus bundle that every register/responder decodes, and ORs-in nothing itself.
- Intended uses: host-interface bridge (UART/USB command parser) and test stimulus for register maps.

---
 rtl/bus_master_pkg.sv | 36 +++
 rtl/bus_master_if.sv | 30 +++
 rtl/bus_master.sv | 134 +++++++++++++
 tb/tb_bus_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// Shared register-bus definitions: bundle widths, field indices and the
// response codes used by bus initiators.
package bus_master_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 32;

  // bus_in (initiator -> responders), named from the responder side
  localparam int BUS_FIELD_RE      = 0;
  localparam int BUS_FIELD_WE      = 1;
  localparam int BUS_WR_DATA_START = 2;
  localparam int BUS_WR_DATA_END   = BUS_WR_DATA_START + BUS_DATA_WIDTH - 1;
  localparam int BUS_ADDR_START    = BUS_WR_DATA_END + 1;
  localparam int BUS_ADDR_END      = BUS_ADDR_START + BUS_ADDR_WIDTH - 1;
  localparam int BUS_FIELD_RESET_L = BUS_ADDR_END + 1;
  localparam int BUS_FIELD_CLK     = BUS_FIELD_RESET_L + 1;
  localparam int BUS_IN_WIDTH      = BUS_FIELD_CLK + 1;

  // bus_out (OR of all responder bundles)
  localparam int BUS_RD_DATA_START = 0;
  localparam int BUS_RD_DATA_END   = BUS_RD_DATA_START + BUS_DATA_WIDTH - 1;
  localparam int BUS_FIELD_RD_ACK  = BUS_RD_DATA_END + 1;
  localparam int BUS_FIELD_WR_ACK  = BUS_FIELD_RD_ACK + 1;
  localparam int BUS_FIELD_IRQ     = BUS_FIELD_WR_ACK + 1;
  localparam int BUS_OUT_WIDTH     = BUS_FIELD_IRQ + 1;

  // Response codes carried on rsp_err
  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

  typedef struct packed {
    logic [BUS_DATA_WIDTH-1:0] rd_data;
    logic                      err;
  } bm_rsp_t;

endpackage

// File: rtl/bus_master_if.sv
// Command/response streams plus the shared register-bus bundle.
interface bus_master_if;
  import bus_master_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [BUS_ADDR_WIDTH-1:0] req_addr;
  logic [BUS_DATA_WIDTH-1:0] req_wr_data;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [BUS_DATA_WIDTH-1:0] rsp_rd_data;
  logic                      rsp_err;

  logic [BUS_IN_WIDTH-1:0]   bus_in;
  logic [BUS_OUT_WIDTH-1:0]  bus_out;
  logic                      bus_irq;

  modport master (
    input  req_valid, req_write, req_addr, req_wr_data, rsp_ready, bus_out,
    output req_ready, rsp_valid, rsp_rd_data, rsp_err, bus_in, bus_irq
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wr_data, rsp_ready, bus_out,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_err, bus_in, bus_irq
  );

endinterface

// File: rtl/bus_master.sv
// Single-outstanding register-bus initiator.
// Optional strobe timeout/abort enabled by defining BUS_MASTER_TIMEOUT_EN;
// without it STROBE waits for the matching ack indefinitely and rsp_err is 0.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a command
// STROBE | bus_re or bus_we high, waiting for the matching ack (or timeout)
// RESP   | rsp_valid high, fields held until rsp_ready
module bus_master
  import bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input logic          bus_clk,
  input logic          bus_reset,
  bus_master_if.master bif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > (32'd1 << TIMEOUT_WIDTH))) begin : g_bad_timeout_cfg
    $error("bus_master: TIMEOUT_CYCLES does not fit TIMEOUT_WIDTH");
  end

  logic [1:0]                state_q, state_d;
  logic                      write_q, write_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  bm_rsp_t                   rsp_q, rsp_d;
  logic                      irq_q;

  logic ack;
  logic timeout;
  logic bus_re, bus_we;

  // Only the ack matching the current strobe type counts
  assign ack = write_q ? bif.bus_out[BUS_FIELD_WR_ACK] : bif.bus_out[BUS_FIELD_RD_ACK];

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout = (state_q == S_STROBE) && !ack &&
                   (tmo_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Count unacked strobe cycles; zero whenever outside STROBE so entry starts at 0
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != S_STROBE) tmo_cnt_d = '0;
    else if (!ack && !timeout) tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
  end

  // Timeout counter register
  always_ff @(posedge bus_clk) begin
    if (bus_reset) tmo_cnt_q <= '0;
    else           tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge bus_clk) begin
    if (bus_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bif.req_valid)   state_d = S_STROBE;
      S_STROBE: if (ack || timeout)  state_d = S_RESP;
      S_RESP:   if (bif.rsp_ready)   state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is held low while reset is asserted
  always_comb begin
    bif.req_ready = (state_q == S_IDLE) && !bus_reset;
    bif.rsp_valid = (state_q == S_RESP);
    bus_re        = (state_q == S_STROBE) && !write_q;
    bus_we        = (state_q == S_STROBE) &&  write_q;
  end

  // Command capture on accept, response capture on ack/timeout
  always_comb begin
    write_d   = write_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rsp_d     = rsp_q;
    if ((state_q == S_IDLE) && bif.req_valid) begin
      write_d   = bif.req_write;
      addr_d    = bif.req_addr;
      wr_data_d = bif.req_wr_data;
    end
    if (state_q == S_STROBE) begin
      if (ack) begin
        rsp_d.rd_data = write_q ? '0 : bif.bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START];
        rsp_d.err     = RSP_OK;
      end else if (timeout) begin
        rsp_d.rd_data = '0;
        rsp_d.err     = RSP_TIMEOUT;
      end
    end
  end

  // Datapath registers; irq is simply re-timed
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      write_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rsp_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      write_q   <= write_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rsp_q     <= rsp_d;
      irq_q     <= bif.bus_out[BUS_FIELD_IRQ];
    end
  end

  // Field order must match the BUS_* indices in the package
  assign bif.bus_in      = {bus_clk, ~bus_reset, addr_q, wr_data_q, bus_we, bus_re};
  assign bif.rsp_rd_data = rsp_q.rd_data;
  assign bif.rsp_err     = rsp_q.err;
  assign bif.bus_irq     = irq_q;

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master with a behavioural register responder.
module tb_bus_master;
  import bus_master_pkg::*;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_master_if bif();

  bus_master #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(16)) dut (
    .bus_clk  (clk),
    .bus_reset(rst),
    .bif      (bif.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int unsigned re_cycles = 0;
  int unsigned we_cycles = 0;
  bm_rsp_t exp_q[$];

  // Responder model
  logic                      bus_re, bus_we, bus_reset_l;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr;
  logic [BUS_DATA_WIDTH-1:0] bus_wr_data;
  int unsigned               ack_after = 0;
  logic                      inject_wr_ack = 1'b0;
  logic                      irq_drv = 1'b0;
  int unsigned               strb_cnt;
  logic [31:0]               reg_q;
  logic                      rd_ack, wr_ack;
  logic [31:0]               rd_data;

  assign bus_re      = bif.bus_in[BUS_FIELD_RE];
  assign bus_we      = bif.bus_in[BUS_FIELD_WE];
  assign bus_reset_l = bif.bus_in[BUS_FIELD_RESET_L];
  assign bus_addr    = bif.bus_in[BUS_ADDR_END:BUS_ADDR_START];
  assign bus_wr_data = bif.bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START];

  always_comb begin
    rd_ack  = bus_re && (strb_cnt == ack_after);
    wr_ack  = (bus_we && (strb_cnt == ack_after)) || (inject_wr_ack && bus_re);
    rd_data = rd_ack ? ((bus_addr == 16'h0010) ? reg_q : 32'h1234_5678)
                     : (bus_re ? 32'hBAD0_0BAD : 32'h0);
  end
  assign bif.bus_out = {irq_drv, wr_ack, rd_ack, rd_data};

  always @(posedge clk) begin
    if (rst) begin
      strb_cnt <= 0;
      reg_q    <= '0;
    end else begin
      strb_cnt <= (bus_re || bus_we) ? strb_cnt + 1 : 0;
      if (bus_we && wr_ack && (bus_addr == 16'h0010)) reg_q <= bus_wr_data;
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: strobe accounting and response scoreboard
  initial begin
    bm_rsp_t e;
    forever begin
      @(negedge clk);
      if (bus_re || bus_we) check("strobe_onehot", 32'(bus_re && bus_we), 32'h0);
      if (bus_re) re_cycles++;
      if (bus_we) we_cycles++;
      if (bif.rsp_valid === 1'b1 && bif.rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 32'h1, 32'h0);
        else begin
          e = exp_q.pop_front();
          check("rsp_rd_data", bif.rsp_rd_data, e.rd_data);
          check("rsp_err", 32'(bif.rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input bit expect_rsp, input logic [31:0] ed, input logic ee);
    int n = 0;
    bif.req_valid   = 1'b1;
    bif.req_write   = wr;
    bif.req_addr    = a;
    bif.req_wr_data = d;
    @(negedge clk);
    while (bif.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(bif.req_ready), 32'h1);
    acc_cyc = cyc;
    if (expect_rsp) exp_q.push_back('{rd_data: ed, err: ee});
    step();
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n = 0;
    @(negedge clk);
    while (bif.rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", 32'(bif.rsp_valid), 32'h1);
    lat = cyc - acc_cyc;
  endtask

  task automatic run(input logic wr, input logic [15:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee,
                     input int exp_lat, input int exp_re, input int exp_we, input string tag);
    int unsigned re0, we0;
    int lat;
    re0 = re_cycles;
    we0 = we_cycles;
    issue(wr, a, d, 1'b1, ed, ee);
    wait_rsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    step();
    check({tag, "_re_cycles"}, 32'(re_cycles - re0), 32'(exp_re));
    check({tag, "_we_cycles"}, 32'(we_cycles - we0), 32'(exp_we));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bif.req_valid   = 1'b0;
    bif.req_write   = 1'b0;
    bif.req_addr    = '0;
    bif.req_wr_data = '0;
    bif.rsp_ready   = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 32'(bif.req_ready), 32'h0);
    check("rst_reset_l", 32'(bus_reset_l), 32'h0);
    check("rst_re", 32'(bus_re), 32'h0);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'h0);
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(bif.req_ready), 32'h1);
    check("idle_reset_l", 32'(bus_reset_l), 32'h1);
    check("idle_we", 32'(bus_we), 32'h0);
    check("idle_addr", 32'(bus_addr), 32'h0);
    check("idle_wr_data", bus_wr_data, 32'h0);
    check("idle_rsp_rd_data", bif.rsp_rd_data, 32'h0);
    check("idle_rsp_err", 32'(bif.rsp_err), 32'h0);
    check("idle_irq", 32'(bif.bus_irq), 32'h0);
    step();

    // Same-cycle responder: write then read back
    run(1'b1, 16'h0010, 32'h0000_00A5, 32'h0, 1'b0, 2, 0, 1, "wr_a5");
    check("reg_after_wr_a5", reg_q, 32'h0000_00A5);
    run(1'b0, 16'h0010, 32'h0, 32'h0000_00A5, 1'b0, 2, 1, 0, "rd_a5");

    // Response backpressure
    bif.rsp_ready = 1'b0;
    issue(1'b0, 16'h0010, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'h2);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bif.rsp_valid), 32'h1);
      check("bp_rd_data", bif.rsp_rd_data, 32'h0000_00A5);
      check("bp_err", 32'(bif.rsp_err), 32'h0);
      check("bp_req_ready", 32'(bif.req_ready), 32'h0);
      step();
      if (i < 4) @(negedge clk);
    end
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_no_overlap", 32'(bif.req_ready), 32'h0);
    step();
    @(negedge clk);
    check("bp_req_ready_back", 32'(bif.req_ready), 32'h1);
    check("bp_rsp_dropped", 32'(bif.rsp_valid), 32'h0);
    step();

    // Delayed responder (ack on 4th strobe cycle); stray wr_ack during read
    ack_after = 3;
    inject_wr_ack = 1'b1;
    run(1'b0, 16'h0010, 32'h0, 32'h0000_00A5, 1'b0, 5, 4, 0, "dly_rd");
    inject_wr_ack = 1'b0;
    run(1'b1, 16'h0010, 32'h0000_003C, 32'h0, 1'b0, 5, 0, 4, "dly_wr");
    check("reg_after_dly_wr", reg_q, 32'h0000_003C);

    // Unmapped address
`ifdef BUS_MASTER_TIMEOUT_EN
    ack_after = 1000;
    run(1'b0, 16'h0200, 32'h0, 32'h0, 1'b1, TMO + 1, TMO, 0, "tmo_rd");
`else
    ack_after = 19;
    run(1'b0, 16'h0200, 32'h0, 32'h1234_5678, 1'b0, 21, 20, 0, "forced_rd");
`endif
    ack_after = 0;

    // IRQ is registered once
    irq_drv = 1'b1;
    @(negedge clk);
    check("irq_lag", 32'(bif.bus_irq), 32'h0);
    step();
    @(negedge clk);
    check("irq_set", 32'(bif.bus_irq), 32'h1);
    step();
    irq_drv = 1'b0;
    step();
    @(negedge clk);
    check("irq_clear", 32'(bif.bus_irq), 32'h0);
    step();

    // Reset while strobing: no response for the aborted cycle
    ack_after = 1000;
    issue(1'b0, 16'h0010, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_mid_strobe_on", 32'(bus_re), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ack_after = 0;
    @(negedge clk);
    check("rst_mid_strobe_off", 32'(bus_re), 32'h0);
    for (int i = 0; i < 6; i++) begin
      check("rst_mid_no_rsp", 32'(bif.rsp_valid), 32'h0);
      @(negedge clk);
    end
    step();
    run(1'b1, 16'h0010, 32'h0000_0077, 32'h0, 1'b0, 2, 0, 1, "post_rst_wr");
    run(1'b0, 16'h0010, 32'h0, 32'h0000_0077, 1'b0, 2, 1, 0, "post_rst_rd");

    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
